// File: rtl/booth_r4_mult_hs.sv
`default_nettype none
// ============================================================================
// Module      : booth_r4_mult_hs
// Description : Sequential radix-4 Booth multiplier with valid/ready handshakes
//               on operand and result sides, per-operation signed/unsigned
//               mode, synchronous abort and a completed-operation counter.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module booth_r4_mult_hs #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 sign_mode,
   input  logic                 abort,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic [CNT_W-1:0]     op_count
);

   // Extended operand width, accumulator (upper half) width, step count.
   localparam int EW = WIDTH + 2;
   localparam int UW = WIDTH + 3;
   localparam int N  = WIDTH / 2 + 1;
   localparam int IW = $clog2(N + 1);
   localparam logic [IW-1:0] C_LAST_ITER = IW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]          r_state;
   logic [EW-1:0]       r_mcand;
   logic [UW-1:0]       r_upper;
   logic [EW-1:0]       r_lower;
   logic                r_prev;
   logic [IW-1:0]       r_iter;
   logic [2*WIDTH-1:0]  r_product;
   logic                r_out_valid;
   logic [CNT_W-1:0]    r_op_count;

   logic [EW-1:0]       w_a_ext;
   logic [EW-1:0]       w_b_ext;
   logic [UW-1:0]       w_a1;
   logic [UW-1:0]       w_a2;
   logic [2:0]          w_trip;
   logic [UW-1:0]       w_pp;
   logic [UW-1:0]       w_sum;
   logic [UW+EW-1:0]    w_shifted;
   logic                w_accept;
   logic                w_out_hs;

   // Operand extension: sign or zero extend to WIDTH+2 so both modes share
   // one signed Booth datapath.
   assign w_a_ext = sign_mode ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
   assign w_b_ext = sign_mode ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

   // Multiples of the multiplicand at accumulator width.
   assign w_a1   = {r_mcand[EW-1], r_mcand};
   assign w_a2   = {r_mcand, 1'b0};
   assign w_trip = {r_lower[1:0], r_prev};

   // Booth recoding of the current multiplier triplet into a partial product.
   always_comb begin
      w_pp = '0;
      case (w_trip)
         3'b001, 3'b010: w_pp = w_a1;
         3'b011:         w_pp = w_a2;
         3'b100:         w_pp = -w_a2;
         3'b101, 3'b110: w_pp = -w_a1;
         default:        w_pp = '0;
      endcase
   end

   // Add into the upper half, then arithmetic shift {upper, lower} right by 2.
   assign w_sum     = r_upper + w_pp;
   assign w_shifted = {{2{w_sum[UW-1]}}, w_sum, r_lower[EW-1:2]};

   // in_ready is also forced low while reset is asserted.
   assign in_ready  = (r_state == S_IDLE) && !abort && rst_n;
   assign w_accept  = in_valid && in_ready;
   assign w_out_hs  = r_out_valid && out_ready;

   assign out_valid = r_out_valid;
   assign product   = r_product;
   assign busy      = (r_state != S_IDLE);
   assign op_count  = r_op_count;

   // Control FSM, Booth iteration datapath, result and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_mcand     <= '0;
         r_upper     <= '0;
         r_lower     <= '0;
         r_prev      <= 1'b0;
         r_iter      <= '0;
         r_product   <= '0;
         r_out_valid <= 1'b0;
         r_op_count  <= '0;
      end else if (abort) begin
         // Abort wins everywhere: drop any result without counting it.
         r_state     <= S_IDLE;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mcand <= w_a_ext;
                  r_lower <= w_b_ext;
                  r_upper <= '0;
                  r_prev  <= 1'b0;
                  r_iter  <= '0;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_upper <= w_shifted[UW+EW-1:EW];
               r_lower <= w_shifted[EW-1:0];
               r_prev  <= r_lower[1];
               if (r_iter == C_LAST_ITER) begin
                  r_product   <= w_shifted[2*WIDTH-1:0];
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_iter <= r_iter + 1'b1;
               end
            end
            S_DONE: begin
               if (w_out_hs) begin
                  r_out_valid <= 1'b0;
                  r_op_count  <= r_op_count + 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_booth_r4_mult_hs.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_r4_mult_hs
// Description : Self-checking bench for booth_r4_mult_hs at WIDTH=8 and 16,
//               directed cases plus randomised operands against an
//               arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_r4_mult_hs;

   logic clk;
   logic rst_n;

   logic        iv8, ir8, sm8, ab8, ov8, or8, busy8;
   logic [7:0]  a8, b8;
   logic [15:0] p8;
   logic [31:0] cnt_dut8;

   logic        iv16, ir16, sm16, ab16, ov16, or16, busy16;
   logic [15:0] a16, b16;
   logic [31:0] p16;
   logic [31:0] cnt_dut16;

   int checks;
   int errors;
   int cnt8;
   int cnt16;

   booth_r4_mult_hs #(.WIDTH(8), .CNT_W(32)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
      .a(a8), .b(b8), .sign_mode(sm8), .abort(ab8),
      .out_valid(ov8), .out_ready(or8), .product(p8),
      .busy(busy8), .op_count(cnt_dut8)
   );

   booth_r4_mult_hs #(.WIDTH(16), .CNT_W(32)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .sign_mode(sm16), .abort(ab16),
      .out_valid(ov16), .out_ready(or16), .product(p16),
      .busy(busy16), .op_count(cnt_dut16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference products from plain integer multiplication.
   function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y,
                                        input logic s);
      int xa, ya;
      xa = s ? int'($signed(x)) : int'(x);
      ya = s ? int'($signed(y)) : int'(y);
      return 16'(xa * ya);
   endfunction

   function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                         input logic s);
      longint xa, ya;
      xa = s ? longint'($signed(x)) : longint'(x);
      ya = s ? longint'($signed(y)) : longint'(y);
      return 32'(xa * ya);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One full 8-bit operation: accept, latency, optional back-pressure, handshake.
   task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input logic s,
                      input int hold, input logic [15:0] exp, input string tag);
      int lat;
      bit stable;
      chk({tag, " in_ready"}, 64'(ir8), 64'd1);
      a8 = aa; b8 = bb; sm8 = s; iv8 = 1'b1;
      @(posedge clk); #1;
      iv8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); sm8 = ~s;
      lat = 0;
      while (!ov8 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'd5);
      chk({tag, " product"}, 64'(p8), 64'(exp));
      if (hold > 0) begin
         stable = 1'b1;
         repeat (hold) begin
            @(posedge clk); #1;
            if (p8 !== exp || ov8 !== 1'b1 || ir8 !== 1'b0 || cnt_dut8 !== 32'(cnt8))
               stable = 1'b0;
         end
         chk({tag, " hold stable"}, 64'(stable), 64'd1);
      end
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
      cnt8++;
      chk({tag, " op_count"}, 64'(cnt_dut8), 64'(cnt8));
      chk({tag, " out_valid low"}, 64'(ov8), 64'd0);
   endtask

   task automatic op16(input logic [15:0] aa, input logic [15:0] bb, input logic s,
                       input int hold, input logic [31:0] exp, input string tag);
      int lat;
      a16 = aa; b16 = bb; sm16 = s; iv16 = 1'b1;
      @(posedge clk); #1;
      iv16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom);
      lat = 0;
      while (!ov16 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, " latency"}, 64'(lat), 64'd9);
      chk({tag, " product"}, 64'(p16), 64'(exp));
      repeat (hold) @(posedge clk);
      #1 or16 = 1'b1;
      @(posedge clk); #1;
      or16 = 1'b0;
      cnt16++;
      chk({tag, " op_count"}, 64'(cnt_dut16), 64'(cnt16));
   endtask

   initial begin
      logic [7:0]  ra8, rb8;
      logic [15:0] ra16, rb16;
      logic        rs;
      bit          seen;

      checks = 0; errors = 0; cnt8 = 0; cnt16 = 0;
      rst_n = 1'b0;
      iv8 = 0; sm8 = 0; ab8 = 0; or8 = 0; a8 = '0; b8 = '0;
      iv16 = 0; sm16 = 0; ab16 = 0; or16 = 0; a16 = '0; b16 = '0;

      // Reset state
      #12;
      chk("reset out_valid", 64'(ov8), 64'd0);
      chk("reset product", 64'(p8), 64'd0);
      chk("reset op_count", 64'(cnt_dut8), 64'd0);
      chk("reset busy", 64'(busy8), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post-reset in_ready", 64'(ir8), 64'd1);

      // 1. Signed directed sequence
      op8(8'h01, 8'hFF, 1'b1, 0, 16'hFFFF, "t1 1*-1");
      op8(8'h80, 8'h7F, 1'b1, 0, 16'hC080, "t1 -128*127");
      op8(8'h80, 8'h80, 1'b1, 0, 16'h4000, "t1 -128*-128");
      op8(8'h7F, 8'h7F, 1'b1, 0, 16'h3F01, "t1 127*127");
      chk("t1 final op_count", 64'(cnt_dut8), 64'd4);

      // 2. Unsigned directed
      op8(8'hFF, 8'hFF, 1'b0, 0, 16'hFE01, "t2 255*255");
      op8(8'h80, 8'hFF, 1'b0, 0, 16'h7F80, "t2 0x80*0xFF");
      op8(8'h00, 8'd200, 1'b0, 0, 16'h0000, "t2 0*200");

      // 3. Back-pressure for 10 cycles
      op8(8'd13, 8'd11, 1'b0, 10, 16'd143, "t3 backpressure");

      // in_ready is low whenever abort is high, even in IDLE
      ab8 = 1'b1; #1;
      chk("abort idle in_ready", 64'(ir8), 64'd0);
      ab8 = 1'b0; #1;
      chk("idle in_ready", 64'(ir8), 64'd1);

      // 4. Abort on the 3rd CALC cycle
      a8 = 8'd50; b8 = 8'd60; sm8 = 1'b0; iv8 = 1'b1;
      @(posedge clk); #1 iv8 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 ab8 = 1'b1;
      @(posedge clk); #1 ab8 = 1'b0;
      chk("t4 abort busy", 64'(busy8), 64'd0);
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (ov8) seen = 1'b1;
      end
      chk("t4 out_valid never rose", 64'(seen), 64'd0);
      chk("t4 op_count", 64'(cnt_dut8), 64'(cnt8));
      op8(8'd3, 8'd5, 1'b0, 0, 16'h000F, "t4 3*5");

      // Abort beats out_ready in DONE
      a8 = 8'd9; b8 = 8'd9; sm8 = 1'b0; iv8 = 1'b1;
      @(posedge clk); #1 iv8 = 1'b0;
      repeat (5) @(posedge clk);
      #1 chk("t4b out_valid", 64'(ov8), 64'd1);
      or8 = 1'b1; ab8 = 1'b1;
      @(posedge clk); #1 or8 = 1'b0; ab8 = 1'b0;
      chk("t4b abort out_valid", 64'(ov8), 64'd0);
      chk("t4b abort op_count", 64'(cnt_dut8), 64'(cnt8));

      // 5. Reset during CALC
      a8 = 8'd100; b8 = 8'd100; sm8 = 1'b0; iv8 = 1'b1;
      @(posedge clk); #1 iv8 = 1'b0;
      @(posedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("t5 rst out_valid", 64'(ov8), 64'd0);
      chk("t5 rst product", 64'(p8), 64'd0);
      chk("t5 rst op_count", 64'(cnt_dut8), 64'd0);
      chk("t5 rst busy", 64'(busy8), 64'd0);
      chk("t5 rst in_ready", 64'(ir8), 64'd0);
      cnt8 = 0;
      cnt16 = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      op8(8'd7, 8'hFD, 1'b1, 0, 16'hFFEB, "t5 7*-3");

      // Randomised 8-bit, both modes
      for (int i = 0; i < 400; i++) begin
         ra8 = 8'($urandom); rb8 = 8'($urandom); rs = 1'(i & 1);
         op8(ra8, rb8, rs, int'($urandom_range(0, 2)), ref8(ra8, rb8, rs), "rand8");
      end

      // 6. WIDTH=16
      op16(16'h8000, 16'h8000, 1'b1, 0, 32'h4000_0000, "t6 -32768^2");
      op16(16'hFFFF, 16'hFFFF, 1'b0, 1, 32'hFFFE_0001, "t6 65535^2");
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 1000; i++) begin
            ra16 = 16'($urandom); rb16 = 16'($urandom); rs = 1'(m);
            op16(ra16, rb16, rs, int'($urandom_range(0, 1)), ref16(ra16, rb16, rs), "rand16");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog: a hung DUT still produces a FAIL line and a summary.
   initial begin
      #3_000_000;
      errors++;
      $display("FAIL watchdog: observed timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
